// File: rtl/uart_mmio_ctrl_if.sv
// rtl/uart_mmio_ctrl_if.sv - MMIO bus and UART byte handshakes for uart_mmio_ctrl
//
// Signals:
//   addr/rd_en/wr_en/wdata/rdata  CPU MMIO access (rdata registered in the controller)
//   inst_retired                  one instruction committed this cycle
//   rx_data/rx_valid/rx_ready     byte stream from uart_receiver
//   tx_data/tx_valid/tx_ready     byte stream to uart_transmitter
// Modports:
//   master  CPU and UART side (drives the requests, sees the controller outputs)
//   slave   the controller

interface uart_mmio_ctrl_if;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        inst_retired;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addr, rd_en, wr_en, wdata, inst_retired, rx_data, rx_valid, tx_ready,
        input  rdata, rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  addr, rd_en, wr_en, wdata, inst_retired, rx_data, rx_valid, tx_ready,
        output rdata, rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - memory-mapped UART controller with RX/TX FIFOs and perf counters
//
// Purpose: buffers bytes between the CPU MMIO window 0x8000_00xx and the UART
// receiver/transmitter, and returns load data one cycle after the access.
// Optional feature macro: UART_MMIO_CTRL_COUNTERS_EN (cycle and retired-instruction
// counters plus the counter-reset register; without it those addresses read 0).
//
// Ports:
//   clk   core clock, rising edge
//   rst   asynchronous active-low reset
//   bus   uart_mmio_ctrl_if.slave (MMIO access, inst_retired, RX and TX byte handshakes)
//
// Register map (full 32-bit address compare):
//   0x8000_0000 status  {29'b0, rx_overflow, rx_not_empty, tx_not_full}, read clears overflow
//   0x8000_0004 RX data (read pops, empty read returns 0)
//   0x8000_0008 TX data (write pushes wdata[7:0], dropped when full)
//   0x8000_0010 cycle counter, 0x8000_0014 retired-instruction counter
//   0x8000_0018 counter reset (any write)

module uart_mmio_ctrl #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_mmio_ctrl_if.slave   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [31:0] ADDR_STATUS  = 32'h8000_0000;
    localparam logic [31:0] ADDR_RX_DATA = 32'h8000_0004;
    localparam logic [31:0] ADDR_TX_DATA = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYCLES  = 32'h8000_0010;
    localparam logic [31:0] ADDR_INSTS   = 32'h8000_0014;
    localparam logic [31:0] ADDR_CNT_RST = 32'h8000_0018;

    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [AW:0]   rx_count;
    logic          rx_overflow;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW:0]   tx_count;

    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;

    // Full/empty come from the occupancy at the start of the cycle, so a
    // same-cycle pop never makes room for a push and vice versa.
    logic rx_full, rx_empty, tx_full, tx_empty;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic status_rd;

    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);

    assign rx_push   = bus.rx_valid && !rx_full;
    assign rx_pop    = bus.rd_en && (bus.addr == ADDR_RX_DATA) && !rx_empty;
    assign tx_push   = bus.wr_en && (bus.addr == ADDR_TX_DATA) && !tx_full;
    assign tx_pop    = !tx_empty && bus.tx_ready;
    assign status_rd = bus.rd_en && (bus.addr == ADDR_STATUS);

    assign bus.rx_ready = 1'b1;
    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_mem[tx_rptr];
    assign bus.rdata    = rdata_q;

    // RX FIFO and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem[i] <= 8'h00;
            end
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_count    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wptr] <= bus.rx_data;
                rx_wptr         <= rx_wptr + AW'(1);
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + AW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (AW+1)'(1);
                2'b01:   rx_count <= rx_count - (AW+1)'(1);
                default: rx_count <= rx_count;
            endcase
            // A new overflow beats the clear from a same-cycle status read.
            if (bus.rx_valid && rx_full) begin
                rx_overflow <= 1'b1;
            end else if (status_rd) begin
                rx_overflow <= 1'b0;
            end
        end
    end

    // TX FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem[i] <= 8'h00;
            end
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wptr] <= bus.wdata[7:0];
                tx_wptr         <= tx_wptr + AW'(1);
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + AW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (AW+1)'(1);
                2'b01:   tx_count <= tx_count - (AW+1)'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

`ifdef UART_MMIO_CTRL_COUNTERS_EN
    logic cnt_clr;
    assign cnt_clr = bus.wr_en && (bus.addr == ADDR_CNT_RST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= 32'd0;
            inst_cnt  <= 32'd0;
        end else if (cnt_clr) begin
            cycle_cnt <= 32'd0;
            inst_cnt  <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            inst_cnt  <= inst_cnt + {31'd0, bus.inst_retired};
        end
    end
`else
    assign cycle_cnt = 32'd0;
    assign inst_cnt  = 32'd0;
`endif

    // Only the low data byte is stored; inst_retired is idle without counters.
    logic unused_ok;
    assign unused_ok = ^{bus.wdata[31:8], bus.inst_retired};

    // Read mux sees pre-cycle state; the result is registered for write-back.
    always_comb begin
        rd_mux = 32'd0;
        case (bus.addr)
            ADDR_STATUS:  rd_mux = {29'd0, rx_overflow, !rx_empty, !tx_full};
            ADDR_RX_DATA: rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr]};
            ADDR_CYCLES:  rd_mux = cycle_cnt;
            ADDR_INSTS:   rd_mux = inst_cnt;
            default:      rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
        end else if (bus.rd_en) begin
            rdata_q <= rd_mux;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - self-checking bench for uart_mmio_ctrl
module tb_uart_mmio_ctrl;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_STAT = 32'h8000_0000;
    localparam logic [31:0] A_RXD  = 32'h8000_0004;
    localparam logic [31:0] A_TXD  = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_INS  = 32'h8000_0014;
    localparam logic [31:0] A_CRST = 32'h8000_0018;
`ifdef UART_MMIO_CTRL_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic        ret;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_mmio_ctrl_if bus ();

    uart_mmio_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: byte queues plus plain counters
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic        m_ovf;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;
    logic [31:0] m_rdata;
    int          hs_count;
    logic [7:0]  hs_bytes[$];

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic rd, input logic wr,
                                input logic [31:0] wd, input logic rxv, input logic [7:0] rxd,
                                input logic txr, input logic ret, input logic chk,
                                input logic [31:0] exp);
        vec_t v;
        v.addr = a; v.rd = rd; v.wr = wr; v.wdata = wd; v.rxv = rxv; v.rxd = rxd;
        v.txr = txr; v.ret = ret; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t rdv(input logic [31:0] a, input logic [31:0] exp);
        return mk(a, 1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, exp);
    endfunction

    function automatic vec_t rxp(input logic [7:0] d);
        return mk(32'd0, 1'b0, 1'b0, 32'd0, 1'b1, d, 1'b0, 1'b0, 1'b0, 32'd0);
    endfunction

    function automatic vec_t wrv(input logic [31:0] a, input logic [31:0] d, input logic txr);
        return mk(a, 1'b0, 1'b1, d, 1'b0, 8'd0, txr, 1'b0, 1'b0, 32'd0);
    endfunction

    function automatic vec_t idle(input logic txr, input logic ret);
        return mk(32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, txr, ret, 1'b0, 32'd0);
    endfunction

    function automatic void model_reset();
        rx_q.delete();
        tx_q.delete();
        m_ovf   = 1'b0;
        m_cyc   = 32'd0;
        m_ins   = 32'd0;
        m_rdata = 32'd0;
    endfunction

    function automatic void model_step(input vec_t v);
        int rxn = rx_q.size();
        int txn = tx_q.size();
        logic [7:0] b;
        if (v.rd) begin
            m_rdata = 32'd0;
            if (v.addr == A_STAT)
                m_rdata = {29'd0, m_ovf, rxn != 0, txn != DEPTH};
            else if (v.addr == A_RXD && rxn != 0)
                m_rdata = {24'd0, rx_q[0]};
            else if (v.addr == A_CYC && CNT_EN)
                m_rdata = m_cyc;
            else if (v.addr == A_INS && CNT_EN)
                m_rdata = m_ins;
        end
        if (v.rd && v.addr == A_RXD && rxn != 0) b = rx_q.pop_front();
        if (v.rxv && rxn < DEPTH) rx_q.push_back(v.rxd);
        if (v.rxv && rxn == DEPTH) m_ovf = 1'b1;
        else if (v.rd && v.addr == A_STAT) m_ovf = 1'b0;
        if (txn != 0 && v.txr) b = tx_q.pop_front();
        if (v.wr && v.addr == A_TXD && txn < DEPTH) tx_q.push_back(v.wdata[7:0]);
        if (CNT_EN && v.wr && v.addr == A_CRST) begin
            m_cyc = 32'd0;
            m_ins = 32'd0;
        end else begin
            m_cyc = m_cyc + 32'd1;
            m_ins = m_ins + {31'd0, v.ret};
        end
    endfunction

    task automatic apply(input vec_t v);
        bus.addr = v.addr; bus.rd_en = v.rd; bus.wr_en = v.wr; bus.wdata = v.wdata;
        bus.rx_valid = v.rxv; bus.rx_data = v.rxd; bus.tx_ready = v.txr; bus.inst_retired = v.ret;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic do_cycle(input vec_t v);
        apply(v);
        #3;
        if (bus.tx_valid && bus.tx_ready) begin
            hs_count++;
            hs_bytes.push_back(bus.tx_data);
        end
        model_step(v);
        @(posedge clk);
        #1;
        check("rdata", bus.rdata, m_rdata);
        check("tx_valid", {31'd0, bus.tx_valid}, {31'd0, tx_q.size() != 0});
        if (tx_q.size() != 0) check("tx_data", {24'd0, bus.tx_data}, {24'd0, tx_q[0]});
        check("rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    endtask

    task automatic do_reset();
        apply(idle(1'b0, 1'b0));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        vec_t v;
        logic [31:0] addrs[7];
        addrs[0] = A_STAT; addrs[1] = A_RXD; addrs[2] = A_TXD; addrs[3] = A_CYC;
        addrs[4] = A_INS;  addrs[5] = A_CRST; addrs[6] = 32'h8000_000C;

        // Table: RX ordering and empty read, then RX overflow
        vecs.push_back(rxp(8'h41));
        vecs.push_back(rxp(8'h42));
        vecs.push_back(rdv(A_STAT, 32'h3));
        vecs.push_back(rdv(A_RXD,  32'h41));
        vecs.push_back(rdv(A_STAT, 32'h3));
        vecs.push_back(rdv(A_RXD,  32'h42));
        vecs.push_back(rdv(A_STAT, 32'h1));
        vecs.push_back(rdv(A_RXD,  32'h0));
        for (int i = 1; i <= 9; i++) vecs.push_back(rxp(8'(i)));
        vecs.push_back(rdv(A_STAT, 32'h7));
        vecs.push_back(rdv(A_STAT, 32'h3));
        for (int i = 1; i <= 8; i++) vecs.push_back(rdv(A_RXD, 32'(i)));
        vecs.push_back(rdv(A_STAT, 32'h1));
        vecs.push_back(rdv(32'h8000_0020, 32'h0));

        // Reset state
        apply(idle(1'b0, 1'b0));
        rst = 1'b0;
        model_reset();
        hs_count = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("reset_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        rst = 1'b1;

        foreach (vecs[i]) begin
            do_cycle(vecs[i]);
            if (vecs[i].chk) check($sformatf("vec%0d", i), bus.rdata, vecs[i].exp);
        end

        // TX backpressure: 9 writes into a depth-8 FIFO with the transmitter stalled
        for (int i = 0; i < 8; i++) do_cycle(wrv(A_TXD, 32'h55, 1'b0));
        do_cycle(rdv(A_STAT, 32'h0));
        check("tx_full_status", bus.rdata, 32'h0);
        do_cycle(wrv(A_TXD, 32'h55, 1'b0));
        hs_count = 0;
        hs_bytes.delete();
        for (int i = 0; i < 12; i++) do_cycle(idle(1'b1, 1'b0));
        check("tx_handshakes", hs_count, 32'd8);
        foreach (hs_bytes[i]) check("tx_hs_byte", {24'd0, hs_bytes[i]}, 32'h55);
        check("tx_drained", {31'd0, bus.tx_valid}, 32'd0);

        // RX full with simultaneous push and pop: push dropped, overflow set
        for (int i = 0; i < 8; i++) do_cycle(rxp(8'(8'h10 + i)));
        v = rdv(A_RXD, 32'h10);
        v.rxv = 1'b1; v.rxd = 8'hEE;
        do_cycle(v);
        check("rx_full_pop", bus.rdata, 32'h10);
        do_cycle(rdv(A_STAT, 32'h7));
        check("rx_sim_status", bus.rdata, 32'h7);
        for (int i = 1; i < 8; i++) do_cycle(rdv(A_RXD, 32'(8'h10 + i)));
        do_cycle(rdv(A_RXD, 32'h0));
        check("rx_occ7_empty", bus.rdata, 32'h0);

        // TX empty with push and tx_ready together: offered next cycle
        do_cycle(wrv(A_TXD, 32'hA5, 1'b1));
        check("tx_sim_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("tx_sim_data", {24'd0, bus.tx_data}, 32'hA5);
        do_cycle(idle(1'b1, 1'b0));

        // Counters
        do_reset();
        for (int i = 0; i < 100; i++) do_cycle(idle(1'b0, i < 40));
        do_cycle(rdv(A_CYC, 32'd0));
        check("cycle_count", bus.rdata, CNT_EN ? 32'd100 : 32'd0);
        do_cycle(rdv(A_INS, 32'd0));
        check("inst_count", bus.rdata, CNT_EN ? 32'd40 : 32'd0);
        do_cycle(wrv(A_CRST, 32'h0, 1'b0));
        do_cycle(rdv(A_INS, 32'd0));
        check("inst_after_clr", bus.rdata, 32'd0);
        do_cycle(rdv(A_CYC, 32'd0));
        check("cycle_after_clr", bus.rdata, CNT_EN ? 32'd1 : 32'd0);

        // Async reset with 3 bytes queued for TX; RX byte during reset is lost
        for (int i = 0; i < 3; i++) do_cycle(wrv(A_TXD, 32'(8'h30 + i), 1'b0));
        apply(idle(1'b0, 1'b0));
        #2;
        rst = 1'b0;
        #1;
        check("async_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("async_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("async_rdata", bus.rdata, 32'd0);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        do_cycle(rdv(A_STAT, 32'h1));
        check("post_reset_status", bus.rdata, 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            v.addr  = ($urandom_range(0, 9) == 0) ? $urandom : addrs[$urandom_range(0, 6)];
            v.rd    = 1'($urandom_range(0, 1));
            v.wr    = ($urandom_range(0, 3) == 0);
            v.wdata = $urandom;
            v.rxv   = ($urandom_range(0, 2) == 0);
            v.rxd   = 8'($urandom);
            v.txr   = 1'($urandom_range(0, 1));
            v.ret   = 1'($urandom_range(0, 1));
            v.chk   = 1'b0;
            v.exp   = 32'd0;
            do_cycle(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
